// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: drives the PC and the instruction-memory request
// port, and owns the IF/ID pipeline register. It keeps one request
// outstanding at a time and discards responses made stale by a redirect.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | just out of reset, first request not yet issued
// REQ   | request outstanding at imem_addr, response will be used
// DROP  | request outstanding but stale, response discarded, tgt_q next
// FULL  | response captured in buf_q while Decode stalls, no request out
module fetch_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            stall_d,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            validD
);

  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    FULL = 2'd3
  } state_t;

  // What happens to IF/ID at the next edge.
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_op_t;

  state_t          state;
  logic [XLEN-1:0] buf_q;
  logic [XLEN-1:0] tgt_q;
  logic [XLEN-1:0] addr_next_seq;

  ifid_op_t        ifid_op;
  logic [XLEN-1:0] ifid_instr;

  // A response only counts while a request is actually outstanding.
  logic            rsp;

  assign rsp           = imem_req & imem_rvalid;
  assign addr_next_seq = imem_addr + INSTR_BYTES;

  // Decide the IF/ID action and the instruction source for this cycle.
  always_comb begin
    ifid_op    = IFID_HOLD;
    ifid_instr = imem_rdata;
    unique case (state)
      IDLE: ifid_op = IFID_BUBBLE;
      REQ: begin
        if (PCSrcE) begin
          ifid_op = IFID_BUBBLE;
        end else if (rsp) begin
          ifid_op = stall_d ? IFID_HOLD : IFID_LOAD;
        end else begin
          ifid_op = stall_d ? IFID_HOLD : IFID_BUBBLE;
        end
      end
      DROP: ifid_op = IFID_BUBBLE;
      FULL: begin
        ifid_instr = buf_q;
        if (PCSrcE) begin
          ifid_op = IFID_BUBBLE;
        end else if (!stall_d) begin
          ifid_op = IFID_LOAD;
        end else begin
          ifid_op = IFID_HOLD;
        end
      end
      default: ifid_op = IFID_BUBBLE;
    endcase
  end

  // IF/ID pipeline register; the loaded PC is always the address just served.
  always_ff @(posedge clk) begin
    if (!rst) begin
      InstrD   <= '0;
      PCD      <= '0;
      PCPlus4D <= '0;
      validD   <= 1'b0;
    end else begin
      unique case (ifid_op)
        IFID_LOAD: begin
          InstrD   <= ifid_instr;
          PCD      <= imem_addr;
          PCPlus4D <= addr_next_seq;
          validD   <= 1'b1;
        end
        IFID_BUBBLE: begin
          InstrD   <= '0;
          PCD      <= '0;
          PCPlus4D <= '0;
          validD   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Fetch FSM with the registered request port, capture buffer and pending target.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      buf_q     <= '0;
      tgt_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          imem_req  <= 1'b1;
          imem_addr <= PCSrcE ? PCTargetE : RESET_PC;
          state     <= REQ;
        end

        REQ: begin
          if (PCSrcE) begin
            if (rsp) begin
              // Response discarded; the target can go out straight away.
              imem_addr <= PCTargetE;
            end else begin
              // Old request must still complete before the target is issued.
              tgt_q <= PCTargetE;
              state <= DROP;
            end
          end else if (rsp) begin
            if (stall_d) begin
              buf_q    <= imem_rdata;
              imem_req <= 1'b0;
              state    <= FULL;
            end else begin
              imem_addr <= addr_next_seq;
            end
          end
        end

        DROP: begin
          if (rsp) begin
            imem_addr <= PCSrcE ? PCTargetE : tgt_q;
            state     <= REQ;
          end else if (PCSrcE) begin
            tgt_q <= PCTargetE;
          end
        end

        FULL: begin
          if (PCSrcE) begin
            buf_q     <= '0;
            imem_req  <= 1'b1;
            imem_addr <= PCTargetE;
            state     <= REQ;
          end else if (!stall_d) begin
            imem_req  <= 1'b1;
            imem_addr <= addr_next_seq;
            state     <= REQ;
          end
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
